// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizes for the FIFO write-port arbiter family.
// Imported by rr_arb_pick and fifo_wr_arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first asserted request at or above i_start,
// wrapping modulo NUM_REQ. Reusable by any arbiter that keeps its own pointer.
module rr_arb_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_start,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  always_comb begin
    logic [IW-1:0] w_scan;
    o_any  = 1'b0;
    o_idx  = '0;
    w_scan = i_start;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_any && i_req[w_scan]) begin
        o_any = 1'b1;
        o_idx = w_scan;
      end
      w_scan = (w_scan == IW'(NUM_REQ - 1)) ? '0 : w_scan + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter in front of the FIFO write port.
// Optional per-requester packet counters: define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  pkt_count
`endif
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || CNT_WIDTH < 1) begin : g_bad_params
    $error("fifo_wr_arbiter: NUM_REQ must be >= 2 and CNT_WIDTH >= 1");
  end

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [IW-1:0]         r_grant_id;
  logic [IW-1:0]         w_grant_nxt;
  logic [IW-1:0]         r_rr_ptr;
  logic [IW-1:0]         w_rr_ptr_nxt;
  logic [IW-1:0]         w_pick_idx;
  logic                  w_pick_any;
  logic                  w_owner_valid;
  logic                  w_owner_last;
  logic [DATA_WIDTH-1:0] w_owner_data;

  // The picker only matters in ARB_IDLE; in ARB_GRANT its result is ignored.
  rr_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .i_req   (req_valid),
    .i_start (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_owner_valid = req_valid[r_grant_id];
  assign w_owner_last  = req_last[r_grant_id];

  always_comb begin
    w_owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == IW'(i)) begin
        w_owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARB_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
    end
  end

  // Outputs depend only on registered state, fifo_full and the owner's valid,
  // so there is no combinational path from any req_valid to req_ready.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant_id;
    w_rr_ptr_nxt  = r_rr_ptr;
    req_ready     = '0;
    fifo_write_en = 1'b0;
    fifo_data_in  = '0;
    busy          = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ARB_GRANT;
          w_grant_nxt = w_pick_idx;
        end
      end
      ARB_GRANT: begin
        busy                  = 1'b1;
        req_ready[r_grant_id] = !fifo_full;
        fifo_write_en         = w_owner_valid && !fifo_full;
        if (fifo_write_en) begin
          fifo_data_in = w_owner_data;
        end
        if (fifo_write_en && w_owner_last) begin
          w_state_nxt  = ARB_IDLE;
          w_rr_ptr_nxt = (r_grant_id == IW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign grant_id = r_grant_id;

`ifdef FIFO_ARB_STATS_EN
  logic w_cnt_inc;

  // fifo_write_en is only ever high in ARB_GRANT, so this marks a completed packet.
  assign w_cnt_inc = fifo_write_en && w_owner_last;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] r_pkt_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_pkt_cnt <= '0;
      end else if (w_cnt_inc && (r_grant_id == IW'(i)) && (r_pkt_cnt != '1)) begin
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
    end

    assign pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = r_pkt_cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a packet-level behavioural model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 2;
  localparam int IW = 2;

  logic            clk     = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic            fifo_full = 1'b0;
  logic [N-1:0]    req_ready;
  logic            fifo_write_en;
  logic [DW-1:0]   fifo_data_in;
  logic [IW-1:0]   grant_id;
  logic            busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*CW-1:0] pkt_count;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model: who (if anyone) owns the port, where the next search starts.
  bit           m_busy  = 1'b0;
  int           m_owner = 0;
  int           m_ptr   = 0;
  int           m_cnt [N];
  logic [N-1:0] hs = '0;

  int           rem [N];
  logic [DW-1:0] dat [N];
  int           wr_ids [$];
  int           wr_cyc [$];
  int           exp_cnt [5] = '{1, 2, 3, 3, 3};

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .grant_id      (grant_id),
    .busy          (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model; inputs are stable from posedge+1 to the next posedge.
  always @(negedge clk) begin
    logic [N-1:0]  e_rdy;
    logic          e_we;
    logic [DW-1:0] e_dat;
    bit            found;
    int            idx;
    hs = req_valid & req_ready;
    if (!reset_n) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      chk("rst_busy", 64'(busy), 0);
      chk("rst_ready", 64'(req_ready), 0);
      chk("rst_we", 64'(fifo_write_en), 0);
      chk("rst_data", 64'(fifo_data_in), 0);
      chk("rst_grant", 64'(grant_id), 0);
    end else begin
      e_rdy = '0;
      e_we  = 1'b0;
      e_dat = '0;
      if (m_busy) begin
        if (!fifo_full) e_rdy[m_owner] = 1'b1;
        e_we = req_valid[m_owner] && !fifo_full;
        if (e_we) e_dat = req_data[m_owner*DW +: DW];
        chk("m_grant", 64'(grant_id), 64'(m_owner));
      end
      chk("m_busy", 64'(busy), 64'(m_busy));
      chk("m_ready", 64'(req_ready), 64'(e_rdy));
      chk("m_we", 64'(fifo_write_en), 64'(e_we));
      chk("m_data", 64'(fifo_data_in), 64'(e_dat));
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("m_pkt_count", 64'(pkt_count[i*CW +: CW]), 64'(m_cnt[i]));
`endif
      if (!m_busy) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!found && req_valid[idx]) begin
            found   = 1'b1;
            m_owner = idx;
          end
        end
        m_busy = found;
      end else if (e_we && req_last[m_owner]) begin
        if (m_cnt[m_owner] < (1 << CW) - 1) m_cnt[m_owner]++;
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
  endtask

  task automatic do_reset();
    step();
    reset_n = 1'b0;
    clear_in();
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    clear_in();
    do_reset();

    // Single 3-beat packet from requester 2.
    step(); req_valid[2] = 1'b1; req_data[2*DW +: DW] = 8'hA1; #2;
    chk("sr_ready_not_comb", 64'(req_ready), 0);
    chk("sr_busy_idle", 64'(busy), 0);
    step(); #2;
    chk("sr_ready2", 64'(req_ready), 64'h4);
    chk("sr_grant2", 64'(grant_id), 2);
    chk("sr_beat1", 64'(fifo_data_in), 64'hA1);
    step(); req_data[2*DW +: DW] = 8'hA2; #2;
    chk("sr_beat2", 64'(fifo_data_in), 64'hA2);
    step(); req_data[2*DW +: DW] = 8'hA3; req_last[2] = 1'b1; #2;
    chk("sr_beat3", 64'(fifo_data_in), 64'hA3);
    chk("sr_we3", 64'(fifo_write_en), 1);
    step(); clear_in();
    req_valid[0] = 1'b1; req_last[0] = 1'b1; req_data[0 +: DW] = 8'h01;
    req_valid[3] = 1'b1; req_last[3] = 1'b1; req_data[3*DW +: DW] = 8'h03; #2;
    chk("sr_busy_drop", 64'(busy), 0);
    step(); #2;
    chk("sr_ptr_is_3", 64'(grant_id), 3);
    chk("sr_ptr_data", 64'(fifo_data_in), 64'h03);
    step(); clear_in();

    // Rotation with every requester continuously offering 1-beat packets.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step();
      req_valid = '1;
      req_last  = '1;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'(8'h30 + i);
      #2;
      if (fifo_write_en) begin
        wr_ids.push_back(int'(grant_id));
        wr_cyc.push_back(c);
      end
    end
    chk("rot_enough_writes", 64'(wr_ids.size() >= 5), 1);
    for (int k = 0; k < 5; k++) begin
      if (k < wr_ids.size()) chk("rot_order", 64'(wr_ids[k]), 64'(k % 4));
      if (k > 0 && k < wr_cyc.size()) chk("rot_gap", 64'(wr_cyc[k] - wr_cyc[k-1]), 2);
    end

    // Packet lock: requester 1 stalls mid-packet while requester 0 waits.
    do_reset();
    step(); req_valid[1] = 1'b1; req_data[1*DW +: DW] = 8'h11; #2;
    step(); req_valid[0] = 1'b1; req_last[0] = 1'b1; req_data[0 +: DW] = 8'h05; #2;
    chk("lock_grant1", 64'(grant_id), 1);
    chk("lock_beat1", 64'(fifo_data_in), 64'h11);
    for (int c = 0; c < 3; c++) begin
      step(); req_valid[1] = 1'b0; #2;
      chk("lock_hold_grant", 64'(grant_id), 1);
      chk("lock_no_write", 64'(fifo_write_en), 0);
    end
    step(); req_valid[1] = 1'b1; req_last[1] = 1'b1; req_data[1*DW +: DW] = 8'h12; #2;
    chk("lock_last_beat", 64'(fifo_data_in), 64'h12);
    step(); req_valid[1] = 1'b0; req_last[1] = 1'b0; #2;
    chk("lock_bubble", 64'(busy), 0);
    step(); #2;
    chk("lock_then_req0", 64'(grant_id), 0);
    chk("lock_req0_data", 64'(fifo_data_in), 64'h05);
    step(); clear_in();

    // Backpressure: full for 4 cycles in the middle of a 4-beat packet.
    do_reset();
    step(); req_valid[2] = 1'b1; req_data[2*DW +: DW] = 8'hB1; #2;
    step(); #2;
    chk("bp_beat1", 64'(fifo_data_in), 64'hB1);
    step(); req_data[2*DW +: DW] = 8'hB2; #2;
    chk("bp_beat2", 64'(fifo_data_in), 64'hB2);
    for (int c = 0; c < 4; c++) begin
      step(); req_data[2*DW +: DW] = 8'hB3; fifo_full = 1'b1; #2;
      chk("bp_ready_low", 64'(req_ready), 0);
      chk("bp_we_low", 64'(fifo_write_en), 0);
      chk("bp_busy_held", 64'(busy), 1);
    end
    step(); fifo_full = 1'b0; #2;
    chk("bp_beat3", 64'(fifo_data_in), 64'hB3);
    chk("bp_we3", 64'(fifo_write_en), 1);
    step(); req_data[2*DW +: DW] = 8'hB4; req_last[2] = 1'b1; #2;
    chk("bp_beat4", 64'(fifo_data_in), 64'hB4);
    step(); clear_in(); #2;
    chk("bp_done", 64'(busy), 0);

    // Asynchronous reset during beat 2 of 4.
    do_reset();
    step(); req_valid[1] = 1'b1; req_data[1*DW +: DW] = 8'hC1; #2;
    step(); #2;
    chk("rm_beat1", 64'(fifo_data_in), 64'hC1);
    step(); req_data[1*DW +: DW] = 8'hC2;
    req_valid[0] = 1'b1; req_last[0] = 1'b1;
    req_valid[3] = 1'b1; req_last[3] = 1'b1;
    #1; reset_n = 1'b0; #1;
    chk("rm_busy0", 64'(busy), 0);
    chk("rm_ready0", 64'(req_ready), 0);
    chk("rm_we0", 64'(fifo_write_en), 0);
    chk("rm_data0", 64'(fifo_data_in), 0);
    step(); reset_n = 1'b1; #2;
    chk("rm_idle_after", 64'(busy), 0);
    step(); #2;
    chk("rm_req0_first", 64'(grant_id), 0);
    step(); clear_in();

`ifdef FIFO_ARB_STATS_EN
    // Saturating packet counter for requester 3.
    do_reset();
    step(); req_valid[3] = 1'b1; req_last[3] = 1'b1; req_data[3*DW +: DW] = 8'h3C;
    for (int k = 0; k < 5; k++) begin
      step(); #2;
      chk("st_write", 64'(fifo_write_en), 1);
      step(); #2;
      chk("st_cnt3", 64'(pkt_count[3*CW +: CW]), 64'(exp_cnt[k]));
      chk("st_cnt_others", 64'(pkt_count[0 +: 3*CW]), 0);
    end
    step(); clear_in();
`endif

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      dat[i] = 8'(i * 64);
    end
    for (int c = 0; c < 1500; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (hs[i] && rem[i] > 0) begin
          rem[i]--;
          dat[i] = dat[i] + 1'b1;
        end
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = int'($urandom_range(1, 4));
        req_valid[i] = (rem[i] > 0) && ($urandom_range(0, 7) != 0);
        req_last[i]  = (rem[i] == 1);
        req_data[i*DW +: DW] = dat[i];
      end
      fifo_full = ($urandom_range(0, 3) == 0);
    end
    step(); clear_in();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
